// File: rtl/reg_file_pkg.sv
// reg_file_pkg: FSM state type and default parameter values for reg_file.
package reg_file_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 1;
endpackage

// File: rtl/reg_file_sb.sv
// reg_file_sb: per-entry busy scoreboard and per-read-port pending flags.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     clr_req,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        hit,
  output logic [NUM_RD-1:0]        rd_busy
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0] busy_q, busy_d;
  // Set is applied after clear so it wins on a same-address collision.
  always_comb begin
    busy_d = busy_q;
    if (we) busy_d[wr_addr] = 1'b0;
    if (busy_set && !(ZERO_REG != 0 && busy_addr == '0)) busy_d[busy_addr] = 1'b1;
    if (!run || clr_req) busy_d = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
  end
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    assign rd_busy[g] = run && busy_q[rd_addr[g*ADDR_W +: ADDR_W]] && !hit[g];
  end
endmodule

// File: rtl/reg_file.sv
// reg_file: multi-read register file with clear sweep, write bypass and busy scoreboard.
// Defining REG_FILE_DBG_EN adds a dbg_addr/dbg_data stored-entry view.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  input  logic                     clr_req,
  output logic                     ready
`ifdef REG_FILE_DBG_EN
  ,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
`endif
);
  localparam int DEPTH = 2**ADDR_W;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic ready_q, ready_d;
  logic wr_ok;
  logic [NUM_RD-1:0] hit;
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_comb begin
    state_d   = (state_q == CLEAR) ? (&clr_ptr_q ? RUN : CLEAR) : (clr_req ? CLEAR : RUN);
    clr_ptr_d = (state_q == CLEAR) ? clr_ptr_q + 1'b1 : '0;
    ready_d   = (state_d == RUN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end
  // Entry 0 is never written when hardwired, so the sweep keeps it at zero.
  assign wr_ok = ready_q && we && !(ZERO_REG != 0 && wr_addr == '0);
  always_ff @(posedge clk) begin
    if (!ready_q) mem_q[clr_ptr_q] <= '0;
    else if (wr_ok) mem_q[wr_addr] <= wr_data;
  end
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    assign hit[g] = wr_ok && (wr_addr == rd_addr[g*ADDR_W +: ADDR_W]);
    assign rd_data[g*DATA_W +: DATA_W] = !ready_q ? '0 : hit[g] ? wr_data : mem_q[rd_addr[g*ADDR_W +: ADDR_W]];
  end
  assign ready = ready_q;
  reg_file_sb #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk), .rst(rst), .run(ready_q), .clr_req(clr_req),
    .busy_set(busy_set), .busy_addr(busy_addr), .we(we), .wr_addr(wr_addr),
    .rd_addr(rd_addr), .hit(hit), .rd_busy(rd_busy)
  );
`ifdef REG_FILE_DBG_EN
  assign dbg_data = ready_q ? mem_q[dbg_addr] : '0;
`endif
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized and directed stimulus against a behavioural register-file model.
module tb_reg_file;
  localparam int AW = 5, DW = 32, NR = 2, DEPTH = 32;
  logic clk = 1'b0, rst = 1'b1, we = 1'b0, busy_set = 1'b0, clr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, busy_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_busy;
  logic ready;
  reg_file dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .busy_set(busy_set),
    .busy_addr(busy_addr), .clr_req(clr_req), .ready(ready)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic rdy;
    logic [NR*DW-1:0] data;
    logic [NR-1:0] bsy;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int checks = 0, errors = 0;
  logic [DW-1:0] m_mem [DEPTH];
  bit m_busy [DEPTH];
  bit m_run;
  int m_left;
  // Sweep modelled as: everything zero at once, then DEPTH cycles not ready.
  function automatic void m_reset();
    m_run = 1'b0;
    m_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction
  function automatic void m_edge();
    if (rst) m_reset();
    else if (!m_run) begin
      m_left--;
      if (m_left == 0) m_run = 1'b1;
    end else if (clr_req) m_reset();
    else begin
      if (we && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (we) m_busy[wr_addr] = 1'b0;
      if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1'b1;
    end
  endfunction
  function automatic exp_t m_expect();
    exp_t e;
    logic [AW-1:0] a;
    bit h;
    e.rdy = m_run && !rst;
    for (int i = 0; i < NR; i++) begin
      a = rd_addr[i*AW +: AW];
      h = e.rdy && we && wr_addr == a && a != 0;
      e.data[i*DW +: DW] = !e.rdy ? '0 : h ? wr_data : m_mem[a];
      e.bsy[i] = e.rdy && m_busy[a] && !h;
    end
    return e;
  endfunction
  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t got %h expected %h", n, $time, act, exp);
    end
  endfunction
  task automatic cyc(input logic r, input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic bs, input logic [AW-1:0] ba, input logic cr,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    @(posedge clk);
    m_edge();
    #1;
    rst = r; we = w; wr_addr = wa; wr_data = wd;
    busy_set = bs; busy_addr = ba; clr_req = cr; rd_addr = {a1, a0};
    if (rst) m_reset();
    q.push_back(m_expect());
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, 0, '0, 0, AW'($urandom), AW'($urandom));
  endtask
  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) cyc(0, 0, '0, '0, 0, '0, 0, AW'(a), AW'(DEPTH-1-a));
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("ready", 64'(ready), 64'(mon_e.rdy));
      chk("rd_data", rd_data, mon_e.data);
      chk("rd_busy", 64'(rd_busy), 64'(mon_e.bsy));
    end
  end
  logic [AW-1:0] ra, rb;
  initial begin
    m_reset();
    repeat (3) cyc(1, 0, '0, '0, 0, '0, 0, '0, '0);
    idle(34);
    read_all();
    cyc(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, 0, 5'd5, 5'd0);
    cyc(0, 0, '0, '0, 0, '0, 0, 5'd5, 5'd5);
    cyc(0, 1, 5'd0, 32'h12345678, 0, '0, 0, 5'd0, 5'd0);
    cyc(0, 0, '0, '0, 1, 5'd0, 0, 5'd0, 5'd0);
    cyc(0, 0, '0, '0, 0, '0, 0, 5'd0, 5'd0);
    cyc(0, 0, '0, '0, 1, 5'd7, 0, 5'd0, 5'd7);
    cyc(0, 0, '0, '0, 0, '0, 0, 5'd7, 5'd7);
    cyc(0, 1, 5'd7, 32'hA5A5A5A5, 0, '0, 0, 5'd0, 5'd7);
    cyc(0, 0, '0, '0, 0, '0, 0, 5'd7, 5'd7);
    cyc(0, 1, 5'd7, 32'h0BADF00D, 1, 5'd7, 0, 5'd7, 5'd7);
    cyc(0, 0, '0, '0, 0, '0, 0, 5'd7, 5'd7);
    for (int a = 1; a < DEPTH; a++)
      cyc(0, 1, AW'(a), 32'h01010101 * a + 32'h1, 1'($urandom), AW'($urandom), 0, AW'(a), AW'(a-1));
    cyc(0, 0, '0, '0, 1, 5'd9, 1, 5'd9, 5'd3);
    for (int i = 0; i < DEPTH; i++)
      cyc(0, 1'($urandom), AW'($urandom), $urandom, 1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom), AW'($urandom));
    read_all();
    cyc(0, 0, '0, '0, 0, '0, 1, '0, '0);
    idle(10);
    cyc(1, 0, '0, '0, 0, '0, 0, '0, '0);
    cyc(1, 0, '0, '0, 0, '0, 0, '0, '0);
    idle(34);
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(3) == 0) ? AW'($urandom) : AW'($urandom_range(7));
      rb = ($urandom_range(3) == 0) ? AW'($urandom) : AW'($urandom_range(7));
      cyc($urandom_range(199) == 0, 1'($urandom), AW'($urandom_range(7)), $urandom,
          1'($urandom), AW'($urandom_range(7)), $urandom_range(63) == 0, ra, rb);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL take parameter DATA_W, 32, register width in bits.
REQ-002 SHALL take parameter ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL take parameter NUM_RD, 2, number of read ports (1..4).
REQ-004 SHALL take parameter ZERO_REG, 1, 1 = entry 0 hardwired to zero.
REQ-005 SHALL have port clk  in  1  single clock; all state changes on posedge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data  out  NUM_RD*DATA_W  packed read data, same packing.
REQ-009 SHALL have port rd_busy  out  NUM_RD  per-port scoreboard-pending flag.
REQ-010 SHALL have port we  in  1  write enable.
REQ-011 SHALL have port wr_addr  in  ADDR_W  write address.
REQ-012 SHALL have port wr_data  in  DATA_W  write data.
REQ-013 SHALL have port busy_set  in  1  mark busy_addr pending.
REQ-014 SHALL have port busy_addr  in  ADDR_W  entry to mark pending.
REQ-015 SHALL have port clr_req  in  1  request full-array clear.
REQ-016 SHALL have port ready  out  1  high when array valid (RUN state).

Function
REQ-017 SHALL implement FSM states CLEAR and RUN; CLEAR writes 0 to entry clr_ptr each cycle, clr_ptr increments by 1.
REQ-018 SHALL move CLEAR->RUN on the edge that clears entry DEPTH-1; clr_ptr returns to 0.
REQ-019 SHALL move RUN->CLEAR on an edge with clr_req=1; clr_req in CLEAR ignored (sweep not restarted).
REQ-020 SHALL register ready = (state==RUN); ready low exactly DEPTH cycles per sweep.
REQ-021 SHALL ignore we and busy_set while in CLEAR; rd_data = 0 and rd_busy = 0 while ready=0.
REQ-022 SHALL perform reads combinationally, zero latency; writes commit on posedge when we=1 in RUN.
REQ-023 SHALL bypass: when we=1 and wr_addr==rd_addr[i] in RUN, rd_data[i] = wr_data same cycle.
REQ-024 SHALL, with ZERO_REG=1, return 0 for address 0, drop writes to 0, never bypass or set busy for address 0.
REQ-025 SHALL set busy[busy_addr] on posedge with busy_set=1; clear busy[wr_addr] on posedge with we=1.
REQ-026 SHALL let set win when busy_set and we hit the same address in one cycle.
REQ-027 SHALL drive rd_busy[i] = busy[rd_addr[i]] AND NOT bypass hit on port i.
REQ-028 SHALL clear all busy bits on entering CLEAR.

Reset
REQ-029 SHALL on rst assertion immediately force state=CLEAR, clr_ptr=0, ready=0, all busy bits 0, rd_data=0, rd_busy=0; array storage has no reset.
REQ-030 SHALL on rst mid-sweep or mid-operation restart the sweep from entry 0 after deassertion.

Configuration
REQ-031 SHALL, with REG_FILE_DBG_EN defined, add ports dbg_addr (in, ADDR_W) and dbg_data (out, DATA_W) giving a combinational, non-bypassed view of the stored entry (0 while ready=0).
REQ-032 SHALL, without REG_FILE_DBG_EN, have no debug ports and no debug logic.

Structure
REQ-033 SHALL place state enum (CLEAR, RUN) and default parameter constants in package reg_file_pkg.
REQ-034 SHALL implement busy bits and rd_busy logic in sub-module reg_file_sb.

Verification
REQ-035 Reset, release -> ready=0 for 32 cycles, then 1; every address reads 0x00000000.
REQ-036 RUN, we=1 wr_addr=5 wr_data=0xDEADBEEF, rd_addr[0]=5 same cycle -> rd_data[0]=0xDEADBEEF that cycle and after.
REQ-037 we=1 wr_addr=0 wr_data=0x12345678 -> reading address 0 returns 0; busy_set addr 0 -> rd_busy stays 0.
REQ-038 busy_set addr 7, next cycle rd_addr[1]=7 -> rd_busy[1]=1; we addr 7 -> rd_busy[1]=0 that cycle and after; busy_set and we addr 7 together -> busy remains 1.
REQ-039 Fill entries 1..31 with non-zero data, pulse clr_req -> ready=0 for 32 cycles, all reads 0, busy cleared, we during sweep lost.
REQ-040 rst asserted at sweep entry 10 -> ready=0 immediately; after release full 32-cycle sweep from entry 0.
